// File: rtl/iram_pkg.sv
// ----------------------------------------------------------------------------
// iram_pkg
// Shared constants, types and pointer helper for the 64 x 85 instruction-RAM
// read-drain path.
//   IRAM_DEPTH  : BRAM entries (power of two)
//   IRAM_WIDTH  : entry width in bits
//   IRAM_PTR_W  : pointer width = address bits + 1 wrap bit
//   IRAM_ADDR_W : BRAM address width
//   ptr_diff()  : modulo-2^PTR_W subtraction of two pointers
// ----------------------------------------------------------------------------
package iram_pkg;

    localparam int unsigned IRAM_DEPTH  = 64;
    localparam int unsigned IRAM_WIDTH  = 85;
    localparam int unsigned IRAM_PTR_W  = 7;
    localparam int unsigned IRAM_ADDR_W = 6;

    typedef logic [IRAM_PTR_W-1:0] iram_ptr_t;
    typedef logic [IRAM_WIDTH-1:0] iram_data_t;

    // Wrap-bit pointers: the difference modulo 2^PTR_W is the fill level and
    // spans 0..DEPTH, so full and empty are distinguishable.
    function automatic iram_ptr_t ptr_diff(input iram_ptr_t a, input iram_ptr_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/iram_skid2_85.sv
// ----------------------------------------------------------------------------
// iram_skid2_85
// Two-entry registered FIFO that absorbs BRAM read data while the consumer
// stalls. Head and valid come straight from flops.
//   clk      in   clock
//   reset_n  in   synchronous active-low reset
//   i_clear  in   drop all contents (and any same-cycle push)
//   i_push   in   write i_din
//   i_din    in   data to write
//   i_pop    in   remove head (ignored when empty)
//   o_valid  out  registered (count != 0)
//   o_head   out  oldest entry
//   o_count  out  entries held, 0..2
// ----------------------------------------------------------------------------
module iram_skid2_85
    import iram_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_push,
    input  iram_data_t i_din,
    input  logic       i_pop,
    output logic       o_valid,
    output iram_data_t o_head,
    output logic [1:0] o_count
);

    iram_data_t r_head;
    iram_data_t r_tail;
    logic [1:0] r_count;
    logic       r_valid;

    iram_data_t w_head_d;
    iram_data_t w_tail_d;
    logic [1:0] w_count_d;
    logic       w_pop;
    logic       w_push;

    assign w_pop  = i_pop & (r_count != 2'd0);
    // A push into a full buffer is only legal alongside a pop; the issue
    // bound upstream guarantees that, so anything else is dropped.
    assign w_push = i_push & ~i_clear & ((r_count != 2'd2) | w_pop);

    always_comb begin
        w_head_d  = r_head;
        w_tail_d  = r_tail;
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_head_d = i_din;
                end else begin
                    w_tail_d = i_din;
                end
                w_count_d = r_count + 2'd1;
            end
            2'b01: begin
                // With one entry left the tail is stale, but valid drops too.
                w_head_d  = r_tail;
                w_count_d = r_count - 2'd1;
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    w_head_d = i_din;
                end else begin
                    w_head_d = r_tail;
                    w_tail_d = i_din;
                end
            end
            default: begin
            end
        endcase
        if (i_clear) begin
            w_count_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_head  <= w_head_d;
            r_tail  <= w_tail_d;
            r_count <= w_count_d;
            r_valid <= (w_count_d != 2'd0);
        end
    end

    assign o_valid = r_valid;
    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/iram_rd_drain_64x85.sv
// ----------------------------------------------------------------------------
// iram_rd_drain_64x85
// Read-side drain engine for a 64 x 85 simple dual-port BRAM. Compares the
// producer write pointer against its own read pointer, issues BRAM reads,
// absorbs the one-cycle read latency in a 2-entry buffer and presents
// entries on a valid/ready stream.
//   clk       in   clock, rising edge
//   reset_n   in   synchronous active-low reset
//   i_wr_ptr  in   producer write pointer (address + wrap bit)
//   i_flush   in   discard unread and buffered entries, rd_ptr <= i_wr_ptr
//   o_enb     out  BRAM read enable (combinational)
//   o_addrb   out  BRAM read address = rd_ptr[5:0]
//   i_dob     in   BRAM read data, valid the cycle after o_enb
//   o_valid   out  output entry valid (registered)
//   o_data    out  output entry (registered)
//   i_ready   in   consumer accept
//   o_rd_ptr  out  registered read pointer, back to the producer
//   o_count   out  unread entries, i_wr_ptr - rd_ptr (combinational)
// ----------------------------------------------------------------------------
module iram_rd_drain_64x85
    import iram_pkg::*;
#(
    parameter int unsigned DEPTH = IRAM_DEPTH,
    parameter int unsigned WIDTH = IRAM_WIDTH,
    parameter int unsigned PTR_W = IRAM_PTR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PTR_W-1:0]         i_wr_ptr,
    input  logic                     i_flush,
    output logic                     o_enb,
    output logic [$clog2(DEPTH)-1:0] o_addrb,
    input  logic [WIDTH-1:0]         i_dob,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    input  logic                     i_ready,
    output logic [PTR_W-1:0]         o_rd_ptr,
    output logic [PTR_W-1:0]         o_count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_inflight;

    logic             w_avail;
    logic             w_pop;
    logic             w_issue;
    logic             w_buf_valid;
    logic [1:0]       w_buf_count;
    logic [2:0]       w_occ_after_pop;
    logic [WIDTH-1:0] w_buf_head;

    assign w_avail = (i_wr_ptr != r_rd_ptr);
    assign w_pop   = w_buf_valid & i_ready;

    // Slots committed once this cycle's pop leaves: buffered + in flight.
    // A pop implies a non-empty buffer, so this never underflows.
    assign w_occ_after_pop = {1'b0, w_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Issue only while a committed slot remains free, so a read that lands
    // next cycle always finds room even if the consumer stalls. reset_n
    // gates the strobe so no read leaks out while in reset.
    assign w_issue = reset_n & w_avail & ~i_flush & (w_occ_after_pop < 3'd2);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr   <= i_wr_ptr;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                // Advancing on the issue edge frees the slot for the producer
                // only after the BRAM has sampled the address.
                r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // The flush also clears the buffer and suppresses the in-flight capture.
    iram_skid2_85 u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (i_flush),
        .i_push  (r_inflight),
        .i_din   (i_dob),
        .i_pop   (w_pop),
        .o_valid (w_buf_valid),
        .o_head  (w_buf_head),
        .o_count (w_buf_count)
    );

    assign o_enb    = w_issue;
    assign o_addrb  = r_rd_ptr[ADDR_W-1:0];
    assign o_valid  = w_buf_valid;
    assign o_data   = w_buf_head;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = ptr_diff(i_wr_ptr, r_rd_ptr);

endmodule
